alu_issue: RTL and testbench

ID/EX issue stage for the MIPS pipeline. It decodes a fetched instruction plus its register-file operands into the ALU's `alu_op` code and its `alu_a`/`alu_b` operands, then holds them in the ID/EX pipeline register. It sits between register read and the ALU, and drives the ALU's operand and opcode interface. It supports a valid/ready handshake, stall, and flush.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_decode.sv | 128 ++++++++++++
 rtl/alu_issue.sv | 101 ++++++++++
 tb/tb_alu_issue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encoding plus MIPS opcode/funct constants shared by the
// issue stage and the ALU. Provides alu_op_t, the decoded-payload struct and
// immediate extension helpers.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  // ALU operation codes. SRL sits at 5'h10 to match the existing ALU encoding.
  typedef enum logic [4:0] {
    ALU_NOP      = 5'h00,
    ALU_ADD      = 5'h01,
    ALU_SUB      = 5'h02,
    ALU_AND      = 5'h03,
    ALU_OR       = 5'h04,
    ALU_XOR      = 5'h05,
    ALU_NOR      = 5'h06,
    ALU_ZERO     = 5'h07,
    ALU_LSHIFT16 = 5'h08,
    ALU_SLL      = 5'h09,
    ALU_SRL      = 5'h10
  } alu_op_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  // Decoded ID/EX payload
  typedef struct packed {
    alu_op_t                 op;
    logic [ALU_DATA_W-1:0]   a;
    logic [ALU_DATA_W-1:0]   b;
    logic [4:0]              rd;
    logic                    reg_write;
    logic                    illegal;
  } alu_dec_t;

  function automatic logic [ALU_DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(ALU_DATA_W-16){imm[15]}}, imm};
  endfunction

  function automatic logic [ALU_DATA_W-1:0] zext16(input logic [15:0] imm);
    return {{(ALU_DATA_W-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational MIPS decode into ALU opcode and operands.
// Ports:
//   instr     in  32  instruction word
//   rs_data   in  32  register rs value
//   rt_data   in  32  register rt value
//   alu_op    out 5   ALU opcode
//   alu_a     out 32  ALU operand a (shift amount for shifts)
//   alu_b     out 32  ALU operand b
//   rd        out 5   destination register (rd for R-type, rt for I-type)
//   reg_write out 1   write-back enable, never set for $0
//   illegal   out 1   instruction not recognised
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  logic [5:0]  opc;
  logic [5:0]  funct;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  alu_dec_t    d;

  assign opc   = instr[31:26];
  assign f_rt  = instr[20:16];
  assign f_rd  = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // Source register indices are resolved upstream; operands arrive as data.
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr[25:21];

  always_comb begin
    d           = '0;
    d.op        = ALU_NOP;
    d.illegal   = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        d.rd        = f_rd;
        d.reg_write = 1'b1;
        d.a         = rs_data;
        d.b         = rt_data;
        case (funct)
          FN_ADD, FN_ADDU: d.op = ALU_ADD;
          FN_SUB, FN_SUBU: d.op = ALU_SUB;
          FN_AND:          d.op = ALU_AND;
          FN_OR:           d.op = ALU_OR;
          FN_XOR:          d.op = ALU_XOR;
          FN_NOR:          d.op = ALU_NOR;
          FN_SLL, FN_SRL: begin
            d.op = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            d.a  = {27'b0, shamt};
          end
          // The ALU shifts by all 32 bits of a, so the amount must be masked.
          FN_SLLV, FN_SRLV: begin
            d.op = (funct == FN_SLLV) ? ALU_SLL : ALU_SRL;
            d.a  = {27'b0, rs_data[4:0]};
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW: begin
        d.op        = ALU_ADD;
        d.a         = rs_data;
        d.b         = sext16(imm);
        d.rd        = f_rt;
        d.reg_write = 1'b1;
      end
      OPC_SW: begin
        d.op = ALU_ADD;
        d.a  = rs_data;
        d.b  = sext16(imm);
        d.rd = f_rt;
      end
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        d.op        = (opc == OPC_ANDI) ? ALU_AND :
                      (opc == OPC_ORI)  ? ALU_OR  : ALU_XOR;
        d.a         = rs_data;
        d.b         = zext16(imm);
        d.rd        = f_rt;
        d.reg_write = 1'b1;
      end
      OPC_LUI: begin
        d.op        = ALU_LSHIFT16;
        d.b         = zext16(imm);
        d.rd        = f_rt;
        d.reg_write = 1'b1;
      end
      OPC_BEQ, OPC_BNE: begin
        d.op = ALU_SUB;
        d.a  = rs_data;
        d.b  = rt_data;
        d.rd = f_rt;
      end
      default: d.illegal = 1'b1;
    endcase

    // Illegal issues as a bubble-like NOP with nothing to write back.
    if (d.illegal) begin
      d.op        = ALU_NOP;
      d.a         = '0;
      d.b         = '0;
      d.rd        = '0;
      d.reg_write = 1'b0;
    end
    if (d.rd == 5'd0) d.reg_write = 1'b0;
  end

  assign alu_op    = d.op;
  assign alu_a     = d.a;
  assign alu_b     = d.b;
  assign rd        = d.rd;
  assign reg_write = d.reg_write;
  assign illegal   = d.illegal;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue stage. Decodes instruction + operands and holds the
// result in the ID/EX register behind a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN (registers ex_illegal and
// keeps a saturating 8-bit illegal_cnt of accepted illegal instructions).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_valid/id_ready upstream handshake (id_ready = !ex_valid || ex_ready)
//   instr, rs_data, rt_data  instruction and operands
//   flush             kill held and incoming instruction
//   ex_valid/ex_ready downstream handshake
//   ex_alu_op, ex_alu_a, ex_alu_b, ex_rd, ex_reg_write, ex_illegal  payload
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [4:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  logic [4:0]        d_op;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;
  logic [4:0]        d_rd;
  logic              d_reg_write;
  logic              d_illegal;
  logic              load;

  alu_decode u_dec (
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .alu_op    (d_op),
    .alu_a     (d_a),
    .alu_b     (d_b),
    .rd        (d_rd),
    .reg_write (d_reg_write),
    .illegal   (d_illegal)
  );

  // Ready depends only on register state, never on id_valid.
  assign id_ready = !ex_valid || ex_ready;
  assign load     = id_valid && id_ready && !flush;

  // Priority: reset > flush > load > drain. With ex_valid && !ex_ready no
  // branch below fires, so the payload holds exactly.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= ALU_NOP;
      ex_alu_a     <= '0;
      ex_alu_b     <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_alu_op    <= d_op;
      ex_alu_a     <= d_a;
      ex_alu_b     <= d_b;
      ex_rd        <= d_rd;
      // Decode already clears this for illegal; kept as a hard guarantee.
      ex_reg_write <= d_reg_write && !d_illegal;
    end else if (ex_ready) begin
      ex_valid     <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic [7:0] illegal_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) ex_illegal <= 1'b0;
    else if (load)    ex_illegal <= d_illegal;
  end

  // Flush only suppresses the load, it never clears the count.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_cnt <= '0;
    else if (load && d_illegal && illegal_cnt != 8'hFF)
      illegal_cnt <= illegal_cnt + 8'd1;
  end
`else
  assign ex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        id_ready, ex_valid, ex_reg_write, ex_illegal;
  logic [4:0]  ex_alu_op, ex_rd;
  logic [31:0] ex_alu_a, ex_alu_b;

  always #5 clk = ~clk;

  alu_issue #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          model_cnt = 0;
  logic        prev_hold = 1'b0;
  logic        prev_zero = 1'b1;
  logic [79:0] snap = '0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] outv();
    return {4'b0, ex_alu_op, ex_alu_a, ex_alu_b, ex_rd, ex_reg_write, ex_illegal};
  endfunction

  // Reference decode, written straight from the instruction table.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt);
    exp_t e;
    int opc, fn;
    logic [31:0] zimm, simm;
    logic legal;
    opc  = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    zimm = {16'h0, ins[15:0]};
    simm = ins[15] ? zimm - 32'h10000 : zimm;
    e.op = 0; e.a = 0; e.b = 0; e.rd = 0; e.wr = 0; e.ill = 0;
    legal = 1'b1;
    if (opc == 0) begin
      e.rd = ins[15:11]; e.wr = 1; e.a = rs; e.b = rt;
      if (fn == 32 || fn == 33)      e.op = 5'h01;
      else if (fn == 34 || fn == 35) e.op = 5'h02;
      else if (fn >= 36 && fn <= 39) e.op = 5'(fn - 33);
      else if (fn == 0 || fn == 2) begin
        e.op = (fn == 0) ? 5'h09 : 5'h10; e.a = {27'h0, ins[10:6]};
      end else if (fn == 4 || fn == 6) begin
        e.op = (fn == 4) ? 5'h09 : 5'h10; e.a = rs % 32;
      end else legal = 1'b0;
    end else begin
      e.rd = ins[20:16]; e.a = rs; e.wr = 1;
      case (opc)
        8, 9, 35:   begin e.op = 5'h01; e.b = simm; end
        43:         begin e.op = 5'h01; e.b = simm; e.wr = 0; end
        12, 13, 14: begin e.op = 5'(opc - 9); e.b = zimm; end
        15:         begin e.op = 5'h08; e.a = 0; e.b = zimm; end
        4, 5:       begin e.op = 5'h02; e.b = rt; e.wr = 0; end
        default:    legal = 1'b0;
      endcase
    end
    if (!legal) begin e.op = 0; e.a = 0; e.b = 0; e.rd = 0; e.wr = 0; end
    if (e.rd == 0) e.wr = 0;
    e.ill = !legal;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  opcs [0:13];
    logic [5:0]  fns  [0:11];
    int k;
    opcs = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
             6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    fns  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
             6'h00, 6'h02, 6'h04, 6'h06};
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 14) w[31:26] = opcs[k];
    k = $urandom_range(0, 13);
    if (w[31:26] == 6'h00 && k < 12) w[5:0] = fns[k];
    return w;
  endfunction

  // One cycle: drive at negedge, check state, update model for the next edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                      input logic [31:0] rtd, input logic rdy, input logic fl,
                      input logic r);
    exp_t e;
    logic acc, empty;
    @(negedge clk);
    id_valid = v; instr = ins; rs_data = rsd; rt_data = rtd;
    ex_ready = rdy; flush = fl; rst = r;
    #1;
    if (prev_hold) chk("hold_stable", outv(), snap);
    if (prev_zero) begin
      chk("kill_valid", {79'b0, ex_valid}, 80'b0);
      chk("kill_payload", outv(), 80'b0);
    end
    empty = (q.size() == 0);
    chk("ex_valid", {79'b0, ex_valid}, {79'b0, !empty});
    chk("id_ready", {79'b0, id_ready}, {79'b0, empty || rdy});
    acc = v && (empty || rdy) && !fl;
    if (r) begin
      q.delete(); model_cnt = 0;
    end else if (fl) begin
      q.delete();
    end else if (acc) begin
      e = ref_model(ins, rsd, rtd);
      q.push_back(e);
      if (e.ill && model_cnt < 255) model_cnt++;
    end
    snap      = outv();
    prev_hold = ex_valid && !rdy && !fl && !r;
    prev_zero = fl || r;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, $urandom, $urandom, $urandom, rdy, 1'b0, 1'b0);
  endtask

  // Monitor: pop and compare whenever EX consumes a held instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !flush && ex_valid && ex_ready) begin
        chk("sb_nonempty", {79'b0, q.size() != 0}, 80'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("op",  {75'b0, ex_alu_op}, {75'b0, e.op});
          chk("a",   {48'b0, ex_alu_a}, {48'b0, e.a});
          chk("b",   {48'b0, ex_alu_b}, {48'b0, e.b});
          if (!e.ill) chk("rd", {75'b0, ex_rd}, {75'b0, e.rd});
          chk("reg_write", {79'b0, ex_reg_write}, {79'b0, e.wr});
          chk("illegal", {79'b0, ex_illegal}, {79'b0, TRAP && e.ill});
        end
      end
    end
  end

  initial begin
    logic [31:0] rt_v, w;
    repeat (2) @(posedge clk);
    // Reset state is checked by the first step (prev_zero starts set).
    idle(1'b1);

    // addi $5,$4,-3 with rs=10
    step(1'b1, {6'h08, 5'd4, 5'd5, 16'hFFFD}, 32'd10, $urandom, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("addi_op", {75'b0, ex_alu_op}, 80'h01);
    chk("addi_a", {48'b0, ex_alu_a}, 80'd10);
    chk("addi_b", {48'b0, ex_alu_b}, 80'hFFFFFFFD);
    chk("addi_rd", {75'b0, ex_rd}, 80'd5);
    chk("addi_wr", {79'b0, ex_reg_write}, 80'd1);

    // lui $3,0x1234 then srlv $2,$1,$7 with rs=0x123
    rt_v = $urandom;
    step(1'b1, {6'h0F, 5'd0, 5'd3, 16'h1234}, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, {6'h00, 5'd7, 5'd1, 5'd2, 5'd0, 6'h06}, 32'h123, rt_v, 1'b1, 1'b0, 1'b0);
    chk("lui_op", {75'b0, ex_alu_op}, 80'h08);
    chk("lui_a", {48'b0, ex_alu_a}, 80'd0);
    chk("lui_b", {48'b0, ex_alu_b}, 80'h1234);
    chk("lui_rd", {75'b0, ex_rd}, 80'd3);
    idle(1'b1);
    chk("srlv_op", {75'b0, ex_alu_op}, 80'h10);
    chk("srlv_a", {48'b0, ex_alu_a}, 80'd3);
    chk("srlv_b", {48'b0, ex_alu_b}, {48'b0, rt_v});

    // ori, then 3 stalled cycles with a new instruction waiting
    step(1'b1, {6'h0D, 5'd1, 5'd6, 16'hA5A5}, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, {6'h00, 5'd10, 5'd11, 5'd9, 5'd0, 6'h22}, 32'd50, 32'd8, 1'b0, 1'b0, 1'b0);
      chk("stall_id_ready", {79'b0, id_ready}, 80'd0);
    end
    step(1'b1, {6'h00, 5'd10, 5'd11, 5'd9, 5'd0, 6'h22}, 32'd50, 32'd8, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("release_op", {75'b0, ex_alu_op}, 80'h02);
    chk("release_rd", {75'b0, ex_rd}, 80'd9);

    // flush with a held instruction and a new one offered
    step(1'b1, {6'h0E, 5'd2, 5'd4, 16'h00FF}, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, {6'h08, 5'd2, 5'd7, 16'h0001}, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("flush_valid", {79'b0, ex_valid}, 80'd0);

    // add $0,$1,$2 never writes back
    step(1'b1, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("r0_wr", {79'b0, ex_reg_write}, 80'd0);

    // illegal opcode 0x3F
    w = $urandom; w[31:26] = 6'h3F;
    step(1'b1, w, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("ill_op", {75'b0, ex_alu_op}, 80'd0);
    chk("ill_wr", {79'b0, ex_reg_write}, 80'd0);
    chk("ill_flag", {79'b0, ex_illegal}, {79'b0, TRAP});

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      w = $urandom; w[31:26] = 6'h3F;
      step(1'b1, w, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    end
    idle(1'b1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("cnt_sat", {72'b0, dut.illegal_cnt}, 80'd255);
    chk("cnt_model", {72'b0, dut.illegal_cnt}, 80'(model_cnt));
`endif

    // reset in the middle of a stall
    step(1'b1, {6'h0D, 5'd1, 5'd6, 16'h1111}, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_id_ready", {79'b0, id_ready}, 80'd1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("cnt_rst", {72'b0, dut.illegal_cnt}, 80'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 150) == 0);
    end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("cnt_random", {72'b0, dut.illegal_cnt}, 80'(model_cnt));
`endif
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("drain", 80'(q.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
